// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Purpose : data-memory handshake bus between the MEM pipeline stage and the
//           data memory.
// Signals : dmem_req   - request, held until dmem_ack
//           dmem_we    - 1 = write, 0 = read (valid while dmem_req = 1)
//           dmem_addr  - byte address
//           dmem_wdata - store data
//           dmem_rdata - load data, valid in the cycle dmem_ack = 1
//           dmem_ack   - one-cycle completion pulse
// Modports: master = pipeline stage, slave = memory.
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Purpose : MEM pipeline stage. Issues loads/stores to data memory over a
//           req/ack handshake, stalls the upstream pipeline while an access
//           is outstanding, and registers the MEM/WB pipeline register.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           RegWr_EX, MemWr_EX,
//           MemRd_EX, WBdata_EX,
//           ALUout_EX, D, npc3,
//           rd3, RPzero_EX        - EX/MEM pipeline register contents
//           dmem (master)         - data-memory handshake bus
//           mem_stall             - hold upstream stages and EX/MEM
//           RegWr_WB, Rd_WB,
//           BusW_WB               - MEM/WB pipeline register
//           mem_err               - sticky access-timeout flag
// Config  : define MEM_TIMEOUT_EN to abandon an access after 256 WAIT cycles
//           without ack; otherwise WAIT is held indefinitely and mem_err = 0.
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWr_EX,
  input  logic        MemWr_EX,
  input  logic        MemRd_EX,
  input  logic [1:0]  WBdata_EX,
  input  logic [31:0] ALUout_EX,
  input  logic [31:0] D,
  input  logic [31:0] npc3,
  input  logic [4:0]  rd3,
  input  logic        RPzero_EX,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic        RegWr_WB,
  output logic [4:0]  Rd_WB,
  output logic [31:0] BusW_WB,
  output logic        mem_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        regwr_wb_q, regwr_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [31:0] busw_wb_q, busw_wb_d;
  logic        op_valid;
  logic        timeout;
  logic        req;
  logic        stall;
  logic [31:0] wb_sel;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    op_valid = (MemRd_EX | MemWr_EX) & ~RPzero_EX;

    timeout = 1'b0;
`ifdef MEM_TIMEOUT_EN
    // cnt_q is 0 in the first WAIT cycle, so 255 marks the 256th WAIT cycle
    timeout = (state_q == WAIT) && (cnt_q == 8'hFF) && !dmem.dmem_ack;
`endif

    // Request is gated by reset so it drops asynchronously; in WAIT it
    // stays high except in the cycle the access is abandoned.
    if (!rst_n)
      req = 1'b0;
    else if (state_q == IDLE)
      req = op_valid;
    else
      req = ~timeout;

    stall = req & ~dmem.dmem_ack;

    state_d = state_q;
    case (state_q)
      IDLE: if (req && !dmem.dmem_ack) state_d = WAIT;
      WAIT: if (dmem.dmem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (WBdata_EX)
      2'b00:   wb_sel = ALUout_EX;
      2'b01:   wb_sel = dmem.dmem_rdata;
      2'b10:   wb_sel = npc3;
      default: wb_sel = 32'h0;
    endcase

    // A stalled cycle inserts a bubble; an abandoned access still advances
    // but must not write the register file.
    if (stall) begin
      regwr_wb_d = 1'b0;
      rd_wb_d    = 5'd0;
      busw_wb_d  = 32'h0;
    end else begin
      regwr_wb_d = RegWr_EX & ~RPzero_EX & ~timeout;
      rd_wb_d    = rd3;
      busw_wb_d  = wb_sel;
    end

`ifdef MEM_TIMEOUT_EN
    cnt_d = (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
    err_d = err_q | timeout;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      regwr_wb_q <= 1'b0;
      rd_wb_q    <= 5'd0;
      busw_wb_q  <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      regwr_wb_q <= regwr_wb_d;
      rd_wb_q    <= rd_wb_d;
      busw_wb_q  <= busw_wb_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // A load+store combination is issued as a write.
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = MemWr_EX;
  assign dmem.dmem_addr  = ALUout_EX;
  assign dmem.dmem_wdata = D;

  assign mem_stall = stall;
  assign RegWr_WB  = regwr_wb_q;
  assign Rd_WB     = rd_wb_q;
  assign BusW_WB   = busw_wb_q;

`ifdef MEM_TIMEOUT_EN
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule
